// File: rtl/mt_pkg.sv
// MT19937 constants, index/word types and index-wrap helpers shared by the
// generator and its tempering stage.
package mt_pkg;

   localparam int unsigned N     = 624;
   localparam int unsigned M     = 397;
   localparam int unsigned IDX_W = 10;

   typedef logic [31:0]      word_t;
   typedef logic [IDX_W-1:0] idx_t;

   localparam word_t MATRIX_A   = 32'h9908_B0DF;
   localparam word_t UPPER_MASK = 32'h8000_0000;
   localparam word_t LOWER_MASK = 32'h7FFF_FFFF;

   localparam word_t TEMPER_B = 32'h9D2C_5680;
   localparam word_t TEMPER_C = 32'hEFC6_0000;
   localparam int unsigned TEMPER_U = 11;
   localparam int unsigned TEMPER_S = 7;
   localparam int unsigned TEMPER_T = 15;
   localparam int unsigned TEMPER_L = 18;

   localparam idx_t IDX_LAST = idx_t'(N - 1);

   function automatic idx_t idx_inc(input idx_t i);
      return (i == IDX_LAST) ? '0 : idx_t'(i + idx_t'(1));
   endfunction

   // i + M folded back into 0..N-1; one extra bit keeps the sum from overflowing.
   function automatic idx_t idx_add_m(input idx_t i);
      logic [IDX_W:0] s;
      s = {1'b0, i} + (IDX_W+1)'(M);
      if (s >= (IDX_W+1)'(N))
         s = s - (IDX_W+1)'(N);
      return s[IDX_W-1:0];
   endfunction

endpackage

// File: rtl/mt_temper.sv
// Combinational MT19937 output tempering.
module mt_temper
   import mt_pkg::*;
(
   input  logic [31:0] word,
   output logic [31:0] tempered
);

   word_t x1, x2, x3;

   always_comb begin
      x1       = word ^ (word >> TEMPER_U);
      x2       = x1 ^ ((x1 << TEMPER_S) & TEMPER_B);
      x3       = x2 ^ ((x2 << TEMPER_T) & TEMPER_C);
      tempered = x3 ^ (x3 >> TEMPER_L);
   end

endmodule

// File: rtl/mersenne_twister.sv
// MT19937 generator: loadable 624-word state, one in-place twist and one
// tempered output word per gen_rv cycle.
module mersenne_twister
   import mt_pkg::*;
(
   input  logic        clk,
   input  logic        n_rst,
   input  logic        load_value,
   input  logic        gen_rv,
   input  logic [31:0] value,
   output logic [31:0] rv
);

   word_t mt [N];
   idx_t  lp, gi, i1, im;
   word_t y, t, t_tempered;
   logic  do_gen;

   // Twisting in place one word at a time means mt[i1] and mt[im] already
   // carry this period's updates once the index wraps, matching genrand_int32.
   always_comb begin
      i1     = idx_inc(gi);
      im     = idx_add_m(gi);
      y      = (mt[gi] & UPPER_MASK) | (mt[i1] & LOWER_MASK);
      t      = mt[im] ^ (y >> 1) ^ (y[0] ? MATRIX_A : '0);
      do_gen = gen_rv & ~load_value;
   end

   mt_temper u_temper (
      .word     (t),
      .tempered (t_tempered)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int k = 0; k < N; k++)
            mt[k] <= '0;
         lp <= '0;
         gi <= '0;
         rv <= '0;
      end else if (load_value) begin
         mt[lp] <= value;
         lp     <= idx_inc(lp);
         gi     <= '0;
      end else if (do_gen) begin
         mt[gi] <= t;
         rv     <= t_tempered;
         gi     <= idx_inc(gi);
      end
   end

endmodule

// File: tb/tb_mersenne_twister.sv
// Directed bench for mersenne_twister with a software MT19937 reference model
// feeding an expected-word queue.
module tb_mersenne_twister;

   logic        tb_clk = 1'b0;
   logic        n_rst;
   logic        load_value;
   logic        gen_rv;
   logic [31:0] value;
   logic [31:0] rv;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_mt [624];
   int          m_gi;
   int          m_lp;
   logic [31:0] last_rv;
   logic [31:0] exp_q [$];
   logic [31:0] init_state [624];

   always #5 tb_clk = ~tb_clk;

   mersenne_twister dut (
      .clk        (tb_clk),
      .n_rst      (n_rst),
      .load_value (load_value),
      .gen_rv     (gen_rv),
      .value      (value),
      .rv         (rv)
   );

   function automatic logic [31:0] ref_temper(input logic [31:0] x);
      logic [31:0] z;
      z = x;
      z = z ^ (z >> 11);
      z = z ^ ((z << 7) & 32'h9D2C5680);
      z = z ^ ((z << 15) & 32'hEFC60000);
      z = z ^ (z >> 18);
      return z;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 624; k++) m_mt[k] = '0;
      m_gi = 0;
      m_lp = 0;
   endfunction

   function automatic void model_load(input logic [31:0] v);
      m_mt[m_lp] = v;
      m_lp = (m_lp + 1) % 624;
      m_gi = 0;
   endfunction

   function automatic logic [31:0] model_gen();
      int          k1, km;
      logic [31:0] y, t;
      k1 = (m_gi + 1) % 624;
      km = (m_gi + 397) % 624;
      y  = (m_mt[m_gi] & 32'h80000000) | (m_mt[k1] & 32'h7FFFFFFF);
      t  = m_mt[km] ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'h0);
      m_mt[m_gi] = t;
      m_gi = (m_gi + 1) % 624;
      return ref_temper(t);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle; a generate pushes the model's word, everything else
   // expects rv to hold.
   task automatic step(input logic ld, input logic gn, input logic [31:0] v, input string tag);
      logic [31:0] e;
      load_value = ld;
      gen_rv     = gn;
      value      = v;
      if (ld) model_load(v);
      else if (gn) exp_q.push_back(model_gen());
      @(posedge tb_clk);
      #1;
      if (gn && !ld) begin
         if (exp_q.size() == 0) begin
            e = 32'hx;
            check({tag, "_queue_empty"}, rv, e);
         end else begin
            e = exp_q.pop_front();
            check(tag, rv, e);
            last_rv = e;
         end
      end else begin
         check(tag, rv, last_rv);
      end
      load_value = 1'b0;
      gen_rv     = 1'b0;
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      #2;
      check("reset_async_rv", rv, 32'h0);
      @(posedge tb_clk);
      #1;
      n_rst = 1'b1;
      model_reset();
      last_rv = '0;
      exp_q.delete();
   endtask

   task automatic load_init_state();
      for (int k = 0; k < 624; k++) begin
         load_value = 1'b1;
         value      = init_state[k];
         model_load(init_state[k]);
         @(posedge tb_clk);
         #1;
      end
      load_value = 1'b0;
   endtask

   initial begin
      n_rst      = 1'b1;
      load_value = 1'b0;
      gen_rv     = 1'b0;
      value      = '0;
      last_rv    = '0;
      model_reset();

      init_state[0] = 32'd5489;
      for (int k = 1; k < 624; k++)
         init_state[k] = 32'd1812433253 * (init_state[k-1] ^ (init_state[k-1] >> 30)) + 32'(k);

      @(posedge tb_clk);
      #1;
      do_reset();
      check("reset_rv", rv, 32'h0);

      step(1'b0, 1'b1, 32'h0, "zero_state_gen");
      check("zero_state_const", rv, 32'h0000_0000);

      do_reset();
      step(1'b1, 1'b0, 32'h8000_0000, "load_msb");
      for (int k = 1; k < 624; k++) begin
         load_value = 1'b1;
         value      = '0;
         model_load('0);
         @(posedge tb_clk);
         #1;
      end
      load_value = 1'b0;
      step(1'b0, 1'b1, 32'h0, "msb_state_gen");
      check("msb_state_const", rv, 32'h4408_1102);

      do_reset();
      load_init_state();
      step(1'b0, 1'b1, 32'h0, "seed_gen1");
      check("seed_const1", rv, 32'd3499211612);
      step(1'b0, 1'b1, 32'h0, "seed_gen2");
      check("seed_const2", rv, 32'd581869302);
      step(1'b0, 1'b1, 32'h0, "seed_gen3");
      check("seed_const3", rv, 32'd3890346734);
      step(1'b0, 1'b0, 32'h0, "idle_hold");

      do_reset();
      load_init_state();
      for (int k = 0; k < 10000; k++)
         step(1'b0, 1'b1, 32'h0, "stream_gen");
      check("stream_10000th", rv, 32'd4123659995);

      // Simultaneous load and generate: load wins (lp has wrapped to 0).
      step(1'b1, 1'b1, 32'h1234_5678, "load_and_gen_rv_hold");
      step(1'b0, 1'b1, 32'h0, "after_collide_gen");
      step(1'b0, 1'b1, 32'h0, "after_collide_gen2");
      step(1'b0, 1'b0, 32'h0, "idle_hold2");

      // Reset in the middle of the 300th load.
      for (int k = 0; k < 299; k++) begin
         load_value = 1'b1;
         value      = init_state[k] ^ 32'hA5A5_5A5A;
         model_load(value);
         @(posedge tb_clk);
         #1;
      end
      load_value = 1'b1;
      value      = 32'hDEAD_BEEF;
      #2;
      n_rst = 1'b0;
      #1;
      check("midload_reset_async_rv", rv, 32'h0);
      @(posedge tb_clk);
      #1;
      load_value = 1'b0;
      n_rst      = 1'b1;
      model_reset();
      last_rv = '0;
      check("midload_reset_rv", rv, 32'h0);
      step(1'b0, 1'b1, 32'h0, "post_reset_gen");
      check("post_reset_const", rv, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mersenne_twister.md
MERSENNE_TWISTER -- requirements
Module: mersenne_twister

Interface
REQ-001 Parameters: none; N=624, M=397 and all MT19937 constants are fixed package constants, not overridable.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 n_rst  input  1  reset; asynchronous, active-low.
REQ-004 load_value  input  1  when high at a rising edge, writes value into the state word at the load pointer.
REQ-005 gen_rv  input  1  when high at a rising edge (and load_value low), produces the next random word.
REQ-006 value  input  32  state word to load.
REQ-007 rv  output  32  most recent tempered MT19937 output, registered.

Function
REQ-008 The block SHALL hold a 624x32-bit state array mt[0..623], a 10-bit load pointer lp, and a 10-bit generate index gi.
REQ-009 On a load_value edge: mt[lp] <= value; lp <= (lp==623) ? 0 : lp+1; gi <= 0.
REQ-010 On a gen_rv edge with load_value low, using i=gi, i1=(i+1) mod 624, im=(i+397) mod 624: y = (mt[i] & 0x80000000) | (mt[i1] & 0x7FFFFFFF); t = mt[im] ^ (y>>1) ^ (y[0] ? 0x9908B0DF : 0).
REQ-011 On that edge: mt[i] <= t; rv <= temper(t); gi <= (gi==623) ? 0 : gi+1.
REQ-012 temper(x): x ^= x>>11; x ^= (x<<7) & 0x9D2C5680; x ^= (x<<15) & 0xEFC60000; x ^= x>>18; all 32-bit, shifted-out bits dropped.
REQ-013 Latency: rv SHALL show the new word after the same rising edge at which gen_rv is sampled high; one word per cycle when gen_rv is held high continuously.
REQ-014 rv SHALL hold its value whenever no generate occurs.
REQ-015 load_value and gen_rv both high: the load is performed, the generate is ignored, and rv is unchanged.
REQ-016 gen_rv before all 624 words are loaded is legal; it operates on current array contents (zeros where unloaded).
REQ-017 Wrap-around: im and i1 SHALL use already-updated words, so the output sequence equals reference MT19937 genrand_int32 from the loaded state, across any number of 624-word periods.
REQ-018 More than 624 loads SHALL wrap lp and overwrite from mt[0].

Reset
REQ-019 While n_rst is low, independent of clk: all mt words = 0, lp = 0, gi = 0, rv = 0.
REQ-020 Reset asserted mid-load or mid-generate SHALL abort the operation; after release the block is idle in the post-reset state above.

Structure
REQ-021 Package mt_pkg SHALL hold N, M, MATRIX_A, UPPER_MASK, LOWER_MASK, the tempering masks and shift amounts, and the index width.
REQ-022 The tempering function SHALL be a purely combinational sub-module mt_temper (32-bit in, 32-bit out); the twist and state live in mersenne_twister.

Verification
REQ-023 Reset, then gen_rv pulse with all-zero state -> rv = 0x00000000.
REQ-024 Reset, load mt[0]=0x80000000 and 623 zeros, one gen_rv -> rv = 0x44081102.
REQ-025 Load the state from init_genrand(5489) (mt[0]=5489, mt[k]=1812433253*(mt[k-1]^(mt[k-1]>>30))+k), then 3 gen_rv -> rv = 3499211612, 581869302, 3890346734.
REQ-026 Same state, 10000 gen_rv with gen_rv held high continuously -> 10000th rv = 4123659995, and every word matches a software MT19937 model (covers the i+397 and 623->0 wrap).
REQ-027 load_value and gen_rv high in the same cycle -> word written, rv unchanged, gi=0; the next gen_rv yields the first word for the new state.
REQ-028 Assert n_rst during the 300th load, then release -> rv=0; a gen_rv then yields 0 (array cleared).
